// File: rtl/instr_fetch_if.sv
// Bundle of the program-load, handshake and status signals of the
// instruction fetch unit. The fetch unit is the slave; whatever feeds it
// (parse stage, loader, testbench) is the master.
interface instr_fetch_if #(
   parameter int IMEM_DEPTH = 64
);
   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;
   logic          branch_taken;
   logic [63:0]   branch_offset;
   logic          instr_ready;
   logic          instr_valid;
   logic [31:0]   instr;
   logic [63:0]   pc;
   logic          halted;
   logic [31:0]   instr_count;

   modport master (
      output prog_we, prog_addr, prog_data,
      output branch_taken, branch_offset, instr_ready,
      input  instr_valid, instr, pc, halted, instr_count
   );

   modport slave (
      input  prog_we, prog_addr, prog_data,
      input  branch_taken, branch_offset, instr_ready,
      output instr_valid, instr, pc, halted, instr_count
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: small word-addressed instruction memory plus a
// fetch FSM that presents one instruction at a time to the parse stage and
// advances (sequentially or by a branch offset) on each accept.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; nothing presented, first fetch issued next edge
// S_FETCH | instr/pc presented (instr_valid=1), waiting for instr_ready
// S_HALT  | next pc was misaligned or outside memory; stopped until reset
module instr_fetch #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [63:0] RESET_PC   = 64'h0
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_if.slave   bus
);
   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   localparam logic [AW-1:0] RST_IDX = RESET_PC[AW+1:2];

   logic [31:0]   mem_q [IMEM_DEPTH];

   logic [1:0]    state_q, state_d;
   logic          valid_q, valid_d;
   logic          halted_q, halted_d;
   logic [63:0]   pc_q, pc_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   count_q, count_d;

   logic          accept;
   logic [63:0]   npc;
   logic          npc_ok;
   logic [AW-1:0] npc_idx;

   // Program port: writes are honoured in every state, reset included, and
   // the array is never cleared. Fetch reads below see the pre-write word
   // on a colliding edge because the array only updates at the edge.
   always_ff @(posedge clk) begin
      if (bus.prog_we) begin
         mem_q[bus.prog_addr] <= bus.prog_data;
      end
   end

   // Next-pc arithmetic: branch offset is in words, wraps modulo 2^64; a
   // target is usable only if word-aligned and inside the memory.
   always_comb begin
      accept  = (state_q == S_FETCH) && valid_q && bus.instr_ready;
      npc     = bus.branch_taken ? (pc_q + (bus.branch_offset << 2))
                                 : (pc_q + 64'd4);
      npc_ok  = (npc[1:0] == 2'b00) && (npc[63:AW+2] == '0);
      npc_idx = npc[AW+1:2];
   end

   // Fetch FSM next-state and output-register next values.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      count_d  = count_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            valid_d = 1'b1;
            pc_d    = RESET_PC;
            instr_d = mem_q[RST_IDX];
         end
         S_FETCH: begin
            if (accept) begin
               if (count_q != 32'hFFFF_FFFF) begin
                  count_d = count_q + 32'd1;
               end
               if (npc_ok) begin
                  pc_d    = npc;
                  instr_d = mem_q[npc_idx];
               end else begin
                  // pc/instr deliberately keep the last presented values
                  state_d  = S_HALT;
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
               end
            end
         end
         S_HALT: begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset wins over any accept on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0;
         count_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         count_q  <= count_d;
      end
   end

   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_q;
   assign bus.pc          = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected output snapshots are queued as
// each step is driven and popped/compared one cycle later.
module tb_instr_fetch;
   localparam int DEPTH = 64;

   typedef struct {
      string       tag;
      logic        valid;
      logic        halted;
      logic [63:0] pc;
      logic [31:0] instr;
      logic [31:0] count;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ref_mem [DEPTH];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   instr_fetch_if #(.IMEM_DEPTH(DEPTH)) bus ();

   instr_fetch #(
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (64'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic v, input logic h,
                       input logic [63:0] p, input logic [31:0] ins, input logic [31:0] c);
      exp_t e;
      e.tag = tag; e.valid = v; e.halted = h; e.pc = p; e.instr = ins; e.count = c;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".valid"},  {63'd0, bus.instr_valid}, {63'd0, e.valid});
         chk({e.tag, ".halted"}, {63'd0, bus.halted},      {63'd0, e.halted});
         chk({e.tag, ".pc"},     bus.pc,                   e.pc);
         chk({e.tag, ".instr"},  {32'd0, bus.instr},       {32'd0, e.instr});
         chk({e.tag, ".count"},  {32'd0, bus.instr_count}, {32'd0, e.count});
      end
   endtask

   task automatic cycle_check();
      @(posedge clk);
      #1;
      check_now();
   endtask

   initial begin
      logic [31:0] pre [4];
      pre[0] = 32'h8B020020; pre[1] = 32'hF84083E1;
      pre[2] = 32'hCB030041; pre[3] = 32'hB4000040;

      reset             = 1'b1;
      bus.prog_we       = 1'b0;
      bus.prog_addr     = '0;
      bus.prog_data     = '0;
      bus.branch_taken  = 1'b0;
      bus.branch_offset = '0;
      bus.instr_ready   = 1'b0;

      // preload the whole memory while held in reset
      for (int i = 0; i < DEPTH; i++) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = 6'(i);
         bus.prog_data = (i < 4) ? pre[i] : (32'hC000_0000 | 32'(i));
         ref_mem[i]    = bus.prog_data;
         @(posedge clk);
         #1;
      end
      bus.prog_we = 1'b0;
      push("reset", 1'b0, 1'b0, 64'd0, 32'h0, 32'd0);
      check_now();

      // release with ready high: boot then sequential accepts
      reset = 1'b0;
      bus.instr_ready = 1'b1;
      push("boot",  1'b1, 1'b0, 64'd0,  ref_mem[0], 32'd0); cycle_check();
      push("seq4",  1'b1, 1'b0, 64'd4,  ref_mem[1], 32'd1); cycle_check();
      push("seq8",  1'b1, 1'b0, 64'd8,  ref_mem[2], 32'd2); cycle_check();
      push("seq12", 1'b1, 1'b0, 64'd12, ref_mem[3], 32'd3); cycle_check();

      // backward branches: 12 -> 8, then 8 with offset -2 -> 0
      bus.branch_taken  = 1'b1;
      bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFF;
      push("br12to8", 1'b1, 1'b0, 64'd8, ref_mem[2], 32'd4); cycle_check();
      bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFE;
      push("br8to0",  1'b1, 1'b0, 64'd0, ref_mem[0], 32'd5); cycle_check();

      // stall with branch_taken toggling; also reprogram word 1
      bus.instr_ready   = 1'b0;
      bus.branch_offset = 64'd7;
      for (int k = 0; k < 5; k++) begin
         bus.branch_taken = k[0];
         bus.prog_we      = (k == 0);
         bus.prog_addr    = 6'd1;
         bus.prog_data    = 32'h1111_1111;
         push("stall", 1'b1, 1'b0, 64'd0, ref_mem[0], 32'd5);
         cycle_check();
         if (k == 0) ref_mem[1] = 32'h1111_1111;
      end

      // write word 1 on the same edge it is fetched: old word expected
      bus.instr_ready  = 1'b1;
      bus.branch_taken = 1'b0;
      bus.prog_we      = 1'b1;
      bus.prog_addr    = 6'd1;
      bus.prog_data    = 32'hAAAA_AAAA;
      push("rdw_old", 1'b1, 1'b0, 64'd4, 32'h1111_1111, 32'd6); cycle_check();
      ref_mem[1]  = 32'hAAAA_AAAA;
      bus.prog_we = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFF;
      push("br4to0",  1'b1, 1'b0, 64'd0, ref_mem[0], 32'd7); cycle_check();
      bus.branch_taken = 1'b0;
      push("refetch", 1'b1, 1'b0, 64'd4, 32'hAAAA_AAAA, 32'd8); cycle_check();
      push("seq8b",   1'b1, 1'b0, 64'd8,  ref_mem[2], 32'd9);  cycle_check();
      push("seq12b",  1'b1, 1'b0, 64'd12, ref_mem[3], 32'd10); cycle_check();
      push("seq16",   1'b1, 1'b0, 64'd16, ref_mem[4], 32'd11); cycle_check();

      // reset on the edge of an accept at pc=16
      reset = 1'b1;
      push("rst_mid", 1'b0, 1'b0, 64'd0, 32'h0, 32'd0); cycle_check();
      reset = 1'b0;
      push("restart", 1'b1, 1'b0, 64'd0, ref_mem[0], 32'd0); cycle_check();

      // branch from 0 by -1 word wraps to a huge address -> halt
      bus.branch_taken  = 1'b1;
      bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFF;
      push("wrap_halt", 1'b0, 1'b1, 64'd0, ref_mem[0], 32'd1); cycle_check();
      bus.branch_taken = 1'b0;
      push("wrap_hold", 1'b0, 1'b1, 64'd0, ref_mem[0], 32'd1); cycle_check();

      // restart, jump to last word, then fall off the end
      reset = 1'b1;
      push("rst2",  1'b0, 1'b0, 64'd0, 32'h0, 32'd0); cycle_check();
      reset = 1'b0;
      push("boot2", 1'b1, 1'b0, 64'd0, ref_mem[0], 32'd0); cycle_check();
      bus.branch_taken  = 1'b1;
      bus.branch_offset = 64'd63;
      push("jump252", 1'b1, 1'b0, 64'd252, ref_mem[63], 32'd1); cycle_check();
      bus.branch_taken = 1'b0;
      push("oob_halt", 1'b0, 1'b1, 64'd252, ref_mem[63], 32'd2); cycle_check();
      for (int k = 0; k < 10; k++) begin
         bus.instr_ready  = k[0];
         bus.branch_taken = k[1];
         push("halt_hold", 1'b0, 1'b1, 64'd252, ref_mem[63], 32'd2);
         cycle_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
